// File: rtl/tqvp_hx2003_pulse_tx_scheduler.sv
// Pulse transmitter job scheduler: queues transmit jobs, launches them one at a time,
// holds an idle gap after each job and flags transmitters that never report busy.
module tqvp_hx2003_pulse_tx_scheduler #(
    parameter int DEPTH          = 4,
    parameter int LAUNCH_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [6:0]             job_end_index,
    input  logic [7:0]             job_loop_count,
    input  logic [15:0]            job_gap,
    input  logic                   abort,
    input  logic                   err_clear,
    output logic                   tx_start,
    output logic [6:0]             tx_end_index,
    output logic [7:0]             tx_loop_count,
    input  logic                   tx_busy,
    output logic                   job_done,
    output logic                   err_timeout,
    output logic                   sched_idle,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [2:0]             dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] TCNT_LAST = 8'(LAUNCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_GAP     = 3'd4
    } state_e;

    typedef struct packed {
        logic [6:0]  end_index;
        logic [7:0]  loop_count;
        logic [15:0] gap;
    } job_t;

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          tx_start_q, tx_start_d;
    logic [6:0]    tx_end_index_q, tx_end_index_d;
    logic [7:0]    tx_loop_count_q, tx_loop_count_d;
    logic [15:0]   gap_q, gap_d;
    logic [15:0]   gcnt_q, gcnt_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          job_done_q, job_done_d;
    logic          err_timeout_q, err_timeout_d;
    logic          timeout_set;

    job_t          mem_q [DEPTH];
    job_t          wr_job;
    job_t          rd_job;
    logic          push;
    logic          pop;

    // Job handshake: a job is taken on every rising edge where job_valid and
    // job_ready are both high; job_ready drops while full or while abort is held.
    assign job_ready = !abort && (count_q < CW'(DEPTH));
    assign push      = job_valid && job_ready;
    assign pop       = !abort && (state_q == S_IDLE) && (count_q != '0);

    assign wr_job.end_index  = job_end_index;
    assign wr_job.loop_count = job_loop_count;
    assign wr_job.gap        = job_gap;
    assign rd_job            = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_job;
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        tx_start_d      = tx_start_q;
        tx_end_index_d  = tx_end_index_q;
        tx_loop_count_d = tx_loop_count_q;
        gap_d           = gap_q;
        gcnt_d          = gcnt_q;
        tcnt_d          = tcnt_q;
        job_done_d      = 1'b0;
        err_timeout_d   = err_timeout_q;
        timeout_set     = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                tx_start_d = 1'b0;
                if (pop) begin
                    tx_end_index_d  = rd_job.end_index;
                    tx_loop_count_d = rd_job.loop_count;
                    gap_d           = rd_job.gap;
                    tcnt_d          = '0;
                    tx_start_d      = 1'b1;
                    state_d         = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start_d = 1'b1;
                tcnt_d     = tcnt_q + 8'd1;
                if (tx_busy) begin
                    state_d = S_RUN;
                end else if (tcnt_q == TCNT_LAST) begin
                    // Transmitter never came up: the job is dropped without job_done.
                    timeout_set = 1'b1;
                    tx_start_d  = 1'b0;
                    state_d     = S_RELEASE;
                end
            end
            S_RUN: begin
                tx_start_d = 1'b1;
                if (!tx_busy) begin
                    job_done_d = 1'b1;
                    tx_start_d = 1'b0;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                tx_start_d = 1'b0;
                gcnt_d     = gap_q;
                state_d    = (gap_q == '0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                tx_start_d = 1'b0;
                gcnt_d     = gcnt_q - 16'd1;
                if (gcnt_q == 16'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        // Abort outranks everything except the sticky error flag.
        if (abort) begin
            state_d     = S_IDLE;
            tx_start_d  = 1'b0;
            count_d     = '0;
            rd_ptr_d    = wr_ptr_q;
            wr_ptr_d    = wr_ptr_q;
            tcnt_d      = '0;
            gcnt_d      = '0;
            job_done_d  = 1'b0;
            timeout_set = 1'b0;
        end

        if (timeout_set) begin
            err_timeout_d = 1'b1;
        end else if (err_clear) begin
            err_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            tx_start_q      <= 1'b0;
            tx_end_index_q  <= '0;
            tx_loop_count_q <= '0;
            gap_q           <= '0;
            gcnt_q          <= '0;
            tcnt_q          <= '0;
            job_done_q      <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            tx_start_q      <= tx_start_d;
            tx_end_index_q  <= tx_end_index_d;
            tx_loop_count_q <= tx_loop_count_d;
            gap_q           <= gap_d;
            gcnt_q          <= gcnt_d;
            tcnt_q          <= tcnt_d;
            job_done_q      <= job_done_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_end_index  = tx_end_index_q;
    assign tx_loop_count = tx_loop_count_q;
    assign job_done      = job_done_q;
    assign err_timeout   = err_timeout_q;
    assign fifo_count    = count_q;
    assign sched_idle    = (state_q == S_IDLE) && (count_q == '0);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv
// Bench for the pulse transmitter job scheduler: timestamp-based reference model,
// per-cycle compare, launch-order scoreboard and directed scenarios.
module tb_tqvp_hx2003_pulse_tx_scheduler;

    localparam int DEPTH          = 4;
    localparam int LAUNCH_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [6:0]  job_end_index;
    logic [7:0]  job_loop_count;
    logic [15:0] job_gap;
    logic        abort;
    logic        err_clear;
    logic        tx_start;
    logic [6:0]  tx_end_index;
    logic [7:0]  tx_loop_count;
    logic        tx_busy;
    logic        job_done;
    logic        err_timeout;
    logic        sched_idle;
    logic [2:0]  fifo_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    tqvp_hx2003_pulse_tx_scheduler #(
        .DEPTH          (DEPTH),
        .LAUNCH_TIMEOUT (LAUNCH_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_end_index  (job_end_index),
        .job_loop_count (job_loop_count),
        .job_gap        (job_gap),
        .abort          (abort),
        .err_clear      (err_clear),
        .tx_start       (tx_start),
        .tx_end_index   (tx_end_index),
        .tx_loop_count  (tx_loop_count),
        .tx_busy        (tx_busy),
        .job_done       (job_done),
        .err_timeout    (err_timeout),
        .sched_idle     (sched_idle),
        .fifo_count     (fifo_count),
        .dbg_state      (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no event expected event at %0t", name, $time);
    endtask

    // Transmitter stand-in: busy rises tx_delay cycles after tx_start and stays tx_hold cycles.
    int tx_mode  = 0;
    int tx_delay = 3;
    int tx_hold  = 40;
    int tx_sc    = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start && tx_mode == 1) begin
                tx_sc++;
                tx_busy = (tx_sc > tx_delay) && (tx_sc <= tx_delay + tx_hold);
            end else begin
                tx_sc   = 0;
                tx_busy = 1'b0;
            end
        end
    end

    // Reference model: job queue plus edge timestamps for launch, completion and next pop.
    logic [30:0] m_q[$];
    logic [30:0] m_cur;
    bit          m_active;
    bit          m_started;
    bit          m_done;
    bit          m_err;
    int          m_e;
    int          m_launch_e;
    int          m_ready_at;

    task automatic model_reset();
        m_q.delete();
        m_cur      = '0;
        m_active   = 1'b0;
        m_started  = 1'b0;
        m_done     = 1'b0;
        m_err      = 1'b0;
        m_e        = 0;
        m_launch_e = 0;
        m_ready_at = 0;
    endtask

    task automatic model_edge();
        bit push_ok;
        bit tset;
        push_ok = job_valid && !abort && (m_q.size() < DEPTH);
        tset    = 1'b0;
        m_done  = 1'b0;
        if (abort) begin
            m_q.delete();
            m_active   = 1'b0;
            m_ready_at = m_e + 1;
        end else begin
            if (m_active) begin
                if (!m_started) begin
                    if (tx_busy) begin
                        m_started = 1'b1;
                    end else if (m_e - m_launch_e == LAUNCH_TIMEOUT) begin
                        tset       = 1'b1;
                        m_active   = 1'b0;
                        m_ready_at = m_e + 2 + int'(m_cur[15:0]);
                    end
                end else if (!tx_busy) begin
                    m_done     = 1'b1;
                    m_active   = 1'b0;
                    m_ready_at = m_e + 2 + int'(m_cur[15:0]);
                end
            end else if (m_e >= m_ready_at && m_q.size() > 0) begin
                m_cur      = m_q.pop_front();
                m_active   = 1'b1;
                m_started  = 1'b0;
                m_launch_e = m_e;
            end
            if (push_ok) begin
                m_q.push_back({job_end_index, job_loop_count, job_gap});
            end
        end
        if (tset) begin
            m_err = 1'b1;
        end else if (err_clear) begin
            m_err = 1'b0;
        end
        m_e++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_edge();
        end
    end

    // Scoreboard and run-length monitor.
    logic [6:0] exp_q[$];
    int         gaps_q[$];
    int         hi_q[$];
    int         done_cnt   = 0;
    int         low_run    = 0;
    int         hi_run     = 0;
    bit         had_high   = 1'b0;
    bit         prev_start = 1'b0;

    task automatic reset_mon();
        gaps_q.delete();
        hi_q.delete();
        had_high = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("tx_start", 32'(tx_start), 32'(m_active));
                check("tx_end_index", 32'(tx_end_index), 32'(m_cur[30:24]));
                check("tx_loop_count", 32'(tx_loop_count), 32'(m_cur[23:16]));
                check("job_done", 32'(job_done), 32'(m_done));
                check("err_timeout", 32'(err_timeout), 32'(m_err));
                check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
                check("sched_idle", 32'(sched_idle),
                      32'(!m_active && m_e >= m_ready_at && m_q.size() == 0));
                check("job_ready", 32'(job_ready), 32'(!abort && m_q.size() < DEPTH));

                if (job_done) done_cnt++;
                if (tx_start) begin
                    if (!prev_start) begin
                        if (had_high) gaps_q.push_back(low_run);
                        if (exp_q.size() > 0) check("launch_order", 32'(tx_end_index), 32'(exp_q.pop_front()));
                        else fail_now("launch_unexpected");
                        hi_run = 0;
                    end
                    hi_run++;
                    had_high = 1'b1;
                end else begin
                    if (prev_start) begin
                        hi_q.push_back(hi_run);
                        low_run = 0;
                    end
                    low_run++;
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_job(input logic [6:0] e, input logic [7:0] l, input logic [15:0] g);
        int t = 0;
        job_valid      = 1'b1;
        job_end_index  = e;
        job_loop_count = l;
        job_gap        = g;
        while (!job_ready && t < 300) begin
            step(1);
            t++;
        end
        if (t >= 300) fail_now("push_wait");
        step(1);
        job_valid = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (!(sched_idle && !tx_start) && t < budget) begin
            step(1);
            t++;
        end
        if (t >= budget) fail_now("wait_idle");
    endtask

    task automatic wait_done(input int budget);
        int t  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < budget) begin
            step(1);
            t++;
        end
        if (t >= budget) fail_now("wait_done");
    endtask

    int d0;
    int exp_gaps[4] = '{2, 5, 2, 3};

    initial begin
        rst_n          = 1'b0;
        job_valid      = 1'b0;
        job_end_index  = '0;
        job_loop_count = '0;
        job_gap        = '0;
        abort          = 1'b0;
        err_clear      = 1'b0;
        #1;
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_end_index", 32'(tx_end_index), 0);
        check("rst_loop_count", 32'(tx_loop_count), 0);
        check("rst_job_done", 32'(job_done), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_idle", 32'(sched_idle), 1);
        check("rst_ready", 32'(job_ready), 1);
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // Single job, busy 3 cycles after launch for 40 cycles.
        tx_mode = 1; tx_hold = 40; reset_mon(); d0 = done_cnt;
        push_job(7'd5, 8'd2, 16'd0);
        check("t1_push_count", 32'(fifo_count), 1);
        check("t1_not_started", 32'(tx_start), 0);
        step(1);
        check("t1_launch", 32'(tx_start), 1);
        check("t1_end_index", 32'(tx_end_index), 5);
        check("t1_loop_count", 32'(tx_loop_count), 2);
        check("t1_popped", 32'(fifo_count), 0);
        wait_idle(200);
        check("t1_done_count", 32'(done_cnt - d0), 1);
        check("t1_high_cycles", 32'((hi_q.size() > 0) ? hi_q[0] : -1), 44);

        // Back-to-back jobs, FIFO fills while the first runs.
        tx_hold = 10; reset_mon(); d0 = done_cnt;
        push_job(7'd10, 8'd1, 16'd0);
        step(1);
        push_job(7'd11, 8'd2, 16'd3);
        push_job(7'd12, 8'd3, 16'd0);
        push_job(7'd13, 8'd4, 16'd1);
        push_job(7'd14, 8'd5, 16'd0);
        check("t2_full_count", 32'(fifo_count), 4);
        check("t2_full_ready", 32'(job_ready), 0);
        wait_idle(400);
        check("t2_done_count", 32'(done_cnt - d0), 5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_low_gap%0d", i), 32'((gaps_q.size() > i) ? gaps_q[i] : -1), 32'(exp_gaps[i]));
        end

        // Launch timeout, then a healthy job, then clear behaviour.
        tx_mode = 0; reset_mon(); d0 = done_cnt;
        push_job(7'd20, 8'd3, 16'd0);
        push_job(7'd21, 8'd4, 16'd0);
        check("t3_pushpop_count", 32'(fifo_count), 1);
        check("t3_launch", 32'(tx_start), 1);
        step(14);
        check("t3_err_before", 32'(err_timeout), 0);
        step(1);
        check("t3_err_after", 32'(err_timeout), 1);
        check("t3_timeout_release", 32'(tx_start), 0);
        tx_mode = 1;
        wait_idle(200);
        check("t3_done_count", 32'(done_cnt - d0), 1);
        check("t3_err_sticky", 32'(err_timeout), 1);
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        check("t3_err_cleared", 32'(err_timeout), 0);
        tx_mode = 0;
        push_job(7'd22, 8'd1, 16'd0);
        step(15);
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        check("t3_set_beats_clear", 32'(err_timeout), 1);
        wait_idle(50);
        err_clear = 1'b1; step(1); err_clear = 1'b0;
        check("t3_err_cleared2", 32'(err_timeout), 0);

        // Abort during RUN with two jobs queued.
        tx_mode = 1; tx_hold = 20; reset_mon(); d0 = done_cnt;
        push_job(7'd30, 8'd1, 16'd0);
        step(1);
        push_job(7'd31, 8'd2, 16'd0);
        push_job(7'd32, 8'd3, 16'd0);
        step(4);
        check("t4_queued", 32'(fifo_count), 2);
        check("t4_running", 32'(tx_start), 1);
        abort = 1'b1;
        #1;
        check("t4_ready_abort", 32'(job_ready), 0);
        @(posedge clk);
        #1;
        check("t4_abort_start", 32'(tx_start), 0);
        check("t4_abort_count", 32'(fifo_count), 0);
        check("t4_abort_done", 32'(job_done), 0);
        abort = 1'b0;
        exp_q.delete();
        step(30);
        check("t4_no_done", 32'(done_cnt - d0), 0);
        check("t4_idle", 32'(sched_idle), 1);

        // Asynchronous reset in the middle of a long gap.
        tx_hold = 5; reset_mon();
        push_job(7'd40, 8'd5, 16'd1000);
        wait_done(100);
        step(10);
        check("t5_in_gap_start", 32'(tx_start), 0);
        check("t5_in_gap_idle", 32'(sched_idle), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_start", 32'(tx_start), 0);
        check("t5_rst_end_index", 32'(tx_end_index), 0);
        check("t5_rst_loop_count", 32'(tx_loop_count), 0);
        check("t5_rst_idle", 32'(sched_idle), 1);
        check("t5_rst_count", 32'(fifo_count), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        reset_mon();
        push_job(7'd41, 8'd6, 16'd0);
        check("t5_push_count", 32'(fifo_count), 1);
        step(1);
        check("t5_launch", 32'(tx_start), 1);
        check("t5_end_index", 32'(tx_end_index), 41);
        wait_idle(100);

        // Simultaneous push/pop and pointer wrap over ten jobs.
        tx_hold = 2; reset_mon(); d0 = done_cnt;
        push_job(7'd50, 8'd0, 16'd0);
        push_job(7'd51, 8'd1, 16'd1);
        check("t6_pushpop_count", 32'(fifo_count), 1);
        for (int i = 2; i < 10; i++) begin
            push_job(7'(50 + i), 8'(i), 16'(i % 3));
        end
        wait_idle(600);
        check("t6_done_count", 32'(done_cnt - d0), 10);
        check("t6_sb_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
